// File: rtl/ex_alu_unit_pkg.sv
// ex_alu_unit_pkg: ALUOp codes shared with the ID-stage decoder plus small helpers
// used by the execute-stage ALU.
package ex_alu_unit_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_BEQ  = 5'd10;
  localparam logic [4:0] ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_BLT  = 5'd12;
  localparam logic [4:0] ALU_BGE  = 5'd13;
  localparam logic [4:0] ALU_BLTU = 5'd14;
  localparam logic [4:0] ALU_BGEU = 5'd15;
  localparam logic [4:0] ALU_IDLE = 5'd16;

  // True for the three shift codes, which may take the multi-cycle path.
  function automatic logic is_shift_op(input logic [4:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/ex_serial_shifter.sv
// ex_serial_shifter: one-bit-per-cycle shifter holding the working value and the
// remaining count. done is high in the cycle whose step produces the final value,
// so the caller can capture value on that same edge.
module ex_serial_shifter #(
  parameter int XLEN = 32,
  parameter int SW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic            dir,
  input  logic            arith,
  input  logic [XLEN-1:0] operand,
  input  logic [SW-1:0]   shamt,
  output logic            done,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] shreg;
  logic [SW-1:0]   count;
  logic            dir_q;
  logic            arith_q;

  // One-position step of the working value; right shifts fill with the sign bit for SRA.
  always_comb begin
    value = '0;
    if (dir_q) value = {arith_q & shreg[XLEN-1], shreg[XLEN-1:1]};
    else       value = {shreg[XLEN-2:0], 1'b0};
  end

  assign done = (count == SW'(1));

  // Load on start, then step and count down until the count is exhausted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      count   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else if (start) begin
      shreg   <= operand;
      count   <= shamt;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (count != '0) begin
      shreg <= value;
      count <= count - SW'(1);
    end
  end

endmodule

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU with a single registered result and valid/ready
// handshakes on both sides. Optional macro EX_BARREL_SHIFT_EN selects a
// single-cycle barrel shifter; without it shifts run one bit per cycle.
module ex_alu_unit
  import ex_alu_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0]   shamt;
  logic            accept;
  logic            load;
  logic [XLEN-1:0] comb_result;
  logic            comb_taken;
  logic [XLEN-1:0] load_result;
  logic            load_taken;

  assign shamt = src_b[SW-1:0];

  // Single-cycle datapath; in the iterative build it only covers shamt 0 for shifts.
  always_comb begin
    comb_result = '0;
    comb_taken  = 1'b0;
    case (alu_op)
      ALU_ADD:  comb_result = src_a + src_b;
      ALU_SUB:  comb_result = src_a - src_b;
      ALU_SLT:  comb_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: comb_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_XOR:  comb_result = src_a ^ src_b;
      ALU_OR:   comb_result = src_a | src_b;
      ALU_AND:  comb_result = src_a & src_b;
`ifdef EX_BARREL_SHIFT_EN
      ALU_SLL:  comb_result = src_a << shamt;
      ALU_SRL:  comb_result = src_a >> shamt;
      ALU_SRA:  comb_result = $unsigned($signed(src_a) >>> shamt);
`else
      ALU_SLL, ALU_SRL, ALU_SRA: comb_result = src_a;
`endif
      ALU_BEQ:  comb_taken = (src_a == src_b);
      ALU_BNE:  comb_taken = (src_a != src_b);
      ALU_BLT:  comb_taken = ($signed(src_a) < $signed(src_b));
      ALU_BGE:  comb_taken = ($signed(src_a) >= $signed(src_b));
      ALU_BLTU: comb_taken = (src_a < src_b);
      ALU_BGEU: comb_taken = (src_a >= src_b);
      default:  ;
    endcase
  end

`ifdef EX_BARREL_SHIFT_EN

  assign in_ready    = !rst && !flush && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign busy        = 1'b0;
  assign load        = accept;
  assign load_result = comb_result;
  assign load_taken  = comb_taken;

`else

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e          state;
  state_e          state_next;
  logic            shift_start;
  logic            shift_done;
  logic [XLEN-1:0] shift_value;

  assign in_ready    = !rst && (state == ST_IDLE) && !flush && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign shift_start = accept && is_shift_op(alu_op) && (shamt != '0);
  assign busy        = (state == ST_SHIFT);
  assign load        = (accept && !shift_start) || (busy && shift_done && !flush);
  assign load_result = busy ? shift_value : comb_result;
  assign load_taken  = busy ? 1'b0 : comb_taken;

  // Next state: enter SHIFT for a nonzero shift, leave when the last step lands; flush wins.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (shift_start) state_next = ST_SHIFT;
      ST_SHIFT: if (shift_done)  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  ex_serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .start   (shift_start),
    .dir     (alu_op != ALU_SLL),
    .arith   (alu_op == ALU_SRA),
    .operand (src_a),
    .shamt   (shamt),
    .done    (shift_done),
    .value   (shift_value)
  );

`endif

  // Output register: flush kills it, a new load wins over draining, data holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid    <= 1'b1;
      result       <= load_result;
      branch_taken <= load_taken;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: directed table-driven bench for ex_alu_unit plus hand-written
// sequences for shifts, stalls, flush and asynchronous reset.
module tb_ex_alu_unit;
  import ex_alu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        tk;
  } vec_t;

  vec_t vecs[18];

  ex_alu_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .src_a        (src_a),
    .src_b        (src_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .busy         (busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    src_a    = a;
    src_b    = b;
  endtask

  // Accept one shift and measure latency, busy cycles and in_ready-low cycles.
  task automatic runShift(input string name, input logic [4:0] op, input logic [31:0] a,
                          input int sh, input logic [31:0] expected);
    int lat;
    int busy_cycles;
    int stall_cycles;
    int exp_lat;
    int exp_busy;
    lat          = 0;
    busy_cycles  = 0;
    stall_cycles = 0;
`ifdef EX_BARREL_SHIFT_EN
    exp_lat  = 1;
    exp_busy = 0;
`else
    exp_lat  = sh + 1;
    exp_busy = sh;
`endif
    applyStimulus(op, a, 32'(sh));
    #1;
    checkOutput({name, "_accept_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      if (busy) busy_cycles++;
      if (!in_ready) stall_cycles++;
      step();
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    checkOutput({name, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_busy));
    checkOutput({name, "_result"}, result, expected);
    checkOutput({name, "_taken"}, 32'(branch_taken), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    alu_op    = ALU_IDLE;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b1;

    vecs[0]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[1]  = '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{ALU_ADD,  32'h00000007, 32'h00000005, 32'h0000000C, 1'b0};
    vecs[3]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[4]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[5]  = '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vecs[6]  = '{ALU_OR,   32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
    vecs[7]  = '{ALU_AND,  32'hFFFF0000, 32'h12345678, 32'h12340000, 1'b0};
    vecs[8]  = '{ALU_BEQ,  32'h0000ABCD, 32'h0000ABCD, 32'h00000000, 1'b1};
    vecs[9]  = '{ALU_BNE,  32'h0000ABCD, 32'h0000ABCD, 32'h00000000, 1'b0};
    vecs[10] = '{ALU_BLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[11] = '{ALU_BLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[12] = '{ALU_BGE,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[13] = '{ALU_BGEU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[14] = '{ALU_IDLE, 32'h11111111, 32'h22222222, 32'h00000000, 1'b0};
    vecs[15] = '{5'h1F,    32'h11111111, 32'h22222222, 32'h00000000, 1'b0};
    vecs[16] = '{ALU_SLL,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[17] = '{ALU_SUB,  32'h00000010, 32'h00000003, 32'h0000000D, 1'b0};

    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_taken", 32'(branch_taken), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("[TB] back-to-back vector table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_result", i), result, vecs[i].res);
      checkOutput($sformatf("vec%0d_taken", i), 32'(branch_taken), 32'(vecs[i].tk));
    end
    in_valid = 1'b0;
    step();
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] shift sequences");
    runShift("sra4", ALU_SRA, 32'h80000000, 4, 32'hF8000000);
    runShift("sll0", ALU_SLL, 32'h00000001, 0, 32'h00000001);
    runShift("sll3", ALU_SLL, 32'h00000001, 3, 32'h00000008);
    runShift("srl4", ALU_SRL, 32'hF0000000, 4, 32'h0F000000);

    $display("[TB] output stall");
    step();
    applyStimulus(ALU_ADD, 32'h00000007, 32'h00000005);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall%0d_result", k), result, 32'h0000000C);
      step();
    end
    out_ready = 1'b1;
    applyStimulus(ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00);
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput("release_out_valid", 32'(out_valid), 32'd1);
    checkOutput("release_result", result, 32'h0FF00FF0);

    $display("[TB] flush during shift");
    applyStimulus(ALU_SRL, 32'h80000000, 32'd31);
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    applyStimulus(ALU_ADD, 32'h00000001, 32'h00000001);
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("flush_dropped_op", 32'(out_valid), 32'd0);
    applyStimulus(ALU_ADD, 32'h00000002, 32'h00000003);
    step();
    in_valid = 1'b0;
    checkOutput("post_flush_valid", 32'(out_valid), 32'd1);
    checkOutput("post_flush_result", result, 32'h00000005);

    $display("[TB] asynchronous reset mid-shift");
    applyStimulus(ALU_SRA, 32'h80000000, 32'd20);
    step();
    in_valid = 1'b0;
    step();
    step();
`ifndef EX_BARREL_SHIFT_EN
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
`endif
    #2;
    rst = 1'b1;
    #1;
    checkOutput("areset_busy", 32'(busy), 32'd0);
    checkOutput("areset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("areset_result", result, 32'd0);
    checkOutput("areset_taken", 32'(branch_taken), 32'd0);
    checkOutput("areset_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    step();
    checkOutput("after_reset_no_output", 32'(out_valid), 32'd0);
    applyStimulus(ALU_IDLE, 32'hAAAAAAAA, 32'h55555555);
    step();
    in_valid = 1'b0;
    checkOutput("idle_token_valid", 32'(out_valid), 32'd1);
    checkOutput("idle_token_result", result, 32'd0);
    checkOutput("idle_token_taken", 32'(branch_taken), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
